// File: rtl/ram_march_bist.sv
// March C- self-test controller for a single-port RAM with combinational read data.
// Define BIST_STOP_ON_FAIL_EN to end the test at the first miscompare.
module ram_march_bist #(
  parameter int ADDR_SIZE = 16,
  parameter int WORD_SIZE = 8,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADDR_SIZE-1:0] fail_addr,
  output logic [WORD_SIZE-1:0] fail_data,
  output logic [2:0]           fail_elem,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 mem_wr,
  output logic                 mem_cs,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

  state_t               state_q, state_d;
  logic [2:0]           elem_q, elem_d;
  logic                 op_q, op_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic                 wr_q, wr_d, cs_q, cs_d;
  logic                 pass_q, pass_d, fail_seen_q, fail_seen_d;
  logic [ADDR_SIZE-1:0] fail_addr_q, fail_addr_d;
  logic [WORD_SIZE-1:0] fail_data_q, fail_data_d;
  logic [2:0]           fail_elem_q, fail_elem_d;

  logic                 elem_up, addr_last_op, at_bound, test_end, mismatch, stop;
  logic [2:0]           nx_elem;
  logic                 nx_op;
  logic [ADDR_SIZE-1:0] nx_addr;

  // op 0 of E1..E5 is the read; E0 is a lone write
  function automatic logic op_is_wr(input logic [2:0] e, input logic o);
    return (e == 3'd0) || o;
  endfunction

  function automatic logic [WORD_SIZE-1:0] op_pat(input logic [2:0] e, input logic o);
    logic ones;
    ones = 1'b0;
    if (e == 3'd1 || e == 3'd3) ones = o;
    else if (e == 3'd2 || e == 3'd4) ones = ~o;
    return {WORD_SIZE{ones}};
  endfunction

  always_comb begin
    elem_up      = (elem_q <= 3'd2);
    addr_last_op = (elem_q == 3'd0) || (elem_q == 3'd5) || op_q;
    at_bound     = elem_up ? (addr_q == LAST_ADDR) : (addr_q == '0);
    test_end     = (elem_q == 3'd5) && (addr_q == '0);
    mismatch     = (state_q == RUN) && cs_q && !wr_q && (mem_rdata != wdata_q);
    nx_elem      = elem_q;
    nx_op        = 1'b0;
    nx_addr      = addr_q;
    if (!addr_last_op) begin
      nx_op = 1'b1;
    end else if (at_bound) begin
      nx_elem = elem_q + 3'd1;
      nx_addr = (elem_q < 3'd2) ? '0 : LAST_ADDR;
    end else begin
      nx_addr = elem_up ? addr_q + ADDR_SIZE'(1) : addr_q - ADDR_SIZE'(1);
    end
  end

`ifdef BIST_STOP_ON_FAIL_EN
  assign stop = test_end || mismatch;
`else
  assign stop = test_end;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN:        if (stop) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
    pass      = pass_q;
    fail_addr = fail_addr_q;
    fail_data = fail_data_q;
    fail_elem = fail_elem_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_wr    = wr_q;
    mem_cs    = cs_q;
  end

  always_comb begin
    elem_d      = elem_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    cs_d        = cs_q;
    pass_d      = pass_q;
    fail_seen_d = fail_seen_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    fail_elem_d = fail_elem_q;
    if (state_q != RUN) begin
      if (start) begin
        // load E0's first write so it is on the bus the cycle busy rises
        elem_d      = '0;
        op_d        = 1'b0;
        addr_d      = '0;
        wdata_d     = '0;
        wr_d        = 1'b1;
        cs_d        = 1'b1;
        pass_d      = 1'b0;
        fail_seen_d = 1'b0;
        fail_addr_d = '0;
        fail_data_d = '0;
        fail_elem_d = '0;
      end
    end else begin
      if (mismatch && !fail_seen_q) begin
        fail_seen_d = 1'b1;
        fail_addr_d = addr_q;
        fail_data_d = mem_rdata;
        fail_elem_d = elem_q;
      end
      if (stop) begin
        cs_d   = 1'b0;
        wr_d   = 1'b0;
        pass_d = !(fail_seen_q || mismatch);
      end else begin
        elem_d  = nx_elem;
        op_d    = nx_op;
        addr_d  = nx_addr;
        wr_d    = op_is_wr(nx_elem, nx_op);
        wdata_d = op_pat(nx_elem, nx_op);
        cs_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      elem_q      <= '0;
      op_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      cs_q        <= 1'b0;
      pass_q      <= 1'b0;
      fail_seen_q <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      fail_elem_q <= '0;
    end else begin
      elem_q      <= elem_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      cs_q        <= cs_d;
      pass_q      <= pass_d;
      fail_seen_q <= fail_seen_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      fail_elem_q <= fail_elem_d;
    end
  end

endmodule

// File: tb/tb_ram_march_bist.sv
// Directed bench for ram_march_bist with a 16-word behavioural RAM and injectable faults.
`timescale 1ns/1ps
module tb_ram_march_bist;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, pass, mem_wr, mem_cs;
  logic [AW-1:0] fail_addr, mem_addr;
  logic [DW-1:0] fail_data, mem_wdata, mem_rdata;
  logic [2:0]    fail_elem;

  logic [DW-1:0] ram [DEPTH];
  int fault = 0;   // 0 none, 1 addr 5 bit 3 stuck-at-0, 2 writes to 11 also hit 3
  int cs_cnt = 0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ram_march_bist #(.ADDR_SIZE(AW), .WORD_SIZE(DW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_data(fail_data), .fail_elem(fail_elem),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_cs(mem_cs),
    .mem_rdata(mem_rdata)
  );

  always @* begin
    mem_rdata = '0;
    if (mem_addr < DEPTH) begin
      mem_rdata = ram[mem_addr[3:0]];
      if (fault == 1 && mem_addr == 8'd5) mem_rdata[3] = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (mem_cs && mem_wr && mem_addr < DEPTH) begin
      ram[mem_addr[3:0]] <= mem_wdata;
      if (fault == 2 && mem_addr == 8'd11) ram[3] <= mem_wdata;
    end
  end

  always @(negedge clk) if (mem_cs) cs_cnt++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    cs_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic wait_done(input string tag);
    int i;
    i = 0;
    while (!done && i < 1000) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_cs_wr"}, {30'd0, mem_cs, mem_wr}, 32'd0);
    chk({tag, "_addr_wdata"}, {16'd0, mem_addr, mem_wdata}, 32'd0);
    chk({tag, "_fail"}, {13'd0, fail_addr, fail_data, fail_elem}, 32'd0);
  endtask

  initial begin
    int i;
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    reset = 1'b1;

    // fault-free run
    fault = 0;
    pulse_start();
    chk("ff_busy_rise", 32'(busy), 32'd1);
    chk("ff_first_op", {mem_cs, mem_wr, mem_addr, mem_wdata}, {2'b11, 8'd0, 8'd0});
    wait_done("ff");
    chk("ff_cs_count", cs_cnt, 32'd160);
    chk("ff_pass", 32'(pass), 32'd1);
    chk("ff_idle_bus", {busy, mem_cs, mem_wr}, 32'd0);
    repeat (5) @(negedge clk);
    #1;
    chk("ff_done_sticky", 32'(done), 32'd1);
    chk("ff_no_cs_after", cs_cnt, 32'd160);

    // restart from DONE, with a start pulse mid-run that must be ignored
    pulse_start();
    chk("re_done_clr", 32'(done), 32'd0);
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("re");
    chk("re_cs_count", cs_cnt, 32'd160);
    chk("re_pass", 32'(pass), 32'd1);

    // stuck-at-0 on bit 3 of word 5
    fault = 1;
    pulse_start();
    wait_done("sa");
    chk("sa_pass", 32'(pass), 32'd0);
    chk("sa_fail_addr", 32'(fail_addr), 32'd5);
    chk("sa_fail_data", 32'(fail_data), 32'hF7);
    chk("sa_fail_elem", 32'(fail_elem), 32'd2);
`ifdef BIST_STOP_ON_FAIL_EN
    chk("sa_cs_count", cs_cnt, 32'd59);
`else
    chk("sa_cs_count", cs_cnt, 32'd160);
`endif
    repeat (5) @(negedge clk);
    #1;
    chk("sa_no_cs_after", 32'(cs_cnt > 160 || (cs_cnt != 59 && cs_cnt != 160)), 32'd0);

    // address decoder alias: writes to 11 also land in 3
    fault = 2;
    pulse_start();
    chk("al_clear_fail", {13'd0, fail_addr, fail_data, fail_elem}, 32'd0);
    wait_done("al");
    chk("al_pass", 32'(pass), 32'd0);
    chk("al_fail_addr", 32'(fail_addr), 32'd3);
    chk("al_fail_data", 32'(fail_data), 32'hFF);
    chk("al_fail_elem", 32'(fail_elem), 32'd3);
`ifdef BIST_STOP_ON_FAIL_EN
    chk("al_cs_count", cs_cnt, 32'd105);
`else
    chk("al_cs_count", cs_cnt, 32'd160);
`endif

    // asynchronous reset in the middle of E3 (ops 81..112)
`ifdef BIST_STOP_ON_FAIL_EN
    fault = 0;
`else
    fault = 1;
`endif
    pulse_start();
    i = 0;
    while (cs_cnt < 90 && i < 500) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk("mr_reached_e3", 32'(cs_cnt >= 90 && busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk_all_zero("mr");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("mr_no_report", {30'd0, busy, done}, 32'd0);
    fault = 0;
    pulse_start();
    wait_done("mr2");
    chk("mr2_cs_count", cs_cnt, 32'd160);
    chk("mr2_pass", 32'(pass), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
